// File: rtl/tlc_phase_scheduler.sv
// Highway/farm-way signal phase sequencer; optional blinking-yellow override under TLC_FLASH_MODE_EN.
// Latency: state, timer and light codes update one clock after a qualifying tick (flash/reset: next clock).
// Backpressure: none; requests are sampled on tick cycles, and only the pedestrian pulse is latched.
module tlc_phase_scheduler #(
  parameter int CNT_W    = 4,
  parameter int T_HG_MIN = 8,
  parameter int T_Y      = 3,
  parameter int T_AR     = 1,
  parameter int T_FG_MIN = 3,
  parameter int T_FG_MAX = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_req,
  input  logic       ped_req,
`ifdef TLC_FLASH_MODE_EN
  input  logic       flash,
`endif
  output logic [1:0] hwy,
  output logic [1:0] fwy,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR1   = 3'd2,
    FG    = 3'd3,
    FY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] HG_LD     = CNT_W'(T_HG_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LD      = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] AR_LD     = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] FG_MIN_LD = CNT_W'(T_FG_MIN - 1);
  localparam logic [CNT_W-1:0] FG_MAX_LD = CNT_W'(T_FG_MAX - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             ped_nxt;
  logic [1:0]       hwy_nxt, fwy_nxt;
  logic             walk_nxt;
`ifdef TLC_FLASH_MODE_EN
  logic             blink, blink_nxt;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
`ifdef TLC_FLASH_MODE_EN
    blink_nxt = blink;
`endif
    case (state)
      HG: if (tick) begin
        if (timer != '0) timer_nxt = timer - CNT_W'(1);
        else if (car_req || ped_pending) begin
          state_nxt = HY;
          timer_nxt = Y_LD;
        end
      end
      HY: if (tick) begin
        if (timer != '0) timer_nxt = timer - CNT_W'(1);
        else begin
          state_nxt = AR1;
          timer_nxt = AR_LD;
        end
      end
      AR1: if (tick) begin
        if (timer != '0) timer_nxt = timer - CNT_W'(1);
        else begin
          state_nxt = FG;
          timer_nxt = '0;
        end
      end
      // Farm green counts up so the min/max limits compare directly against elapsed ticks.
      FG: if (tick) begin
        if ((timer >= FG_MIN_LD && !car_req) || timer == FG_MAX_LD) begin
          state_nxt = FY;
          timer_nxt = Y_LD;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      FY: if (tick) begin
        if (timer != '0) timer_nxt = timer - CNT_W'(1);
        else begin
          state_nxt = AR2;
          timer_nxt = AR_LD;
        end
      end
      AR2: if (tick) begin
        if (timer != '0) timer_nxt = timer - CNT_W'(1);
        else begin
          state_nxt = HG;
          timer_nxt = HG_LD;
        end
      end
`ifdef TLC_FLASH_MODE_EN
      FLASH: if (tick) blink_nxt = ~blink;
`endif
      default: begin
        state_nxt = AR2;
        timer_nxt = AR_LD;
      end
    endcase
`ifdef TLC_FLASH_MODE_EN
    if (flash) begin
      state_nxt = FLASH;
      if (state != FLASH) blink_nxt = 1'b0;
    end else if (state == FLASH) begin
      state_nxt = AR1;
      timer_nxt = AR_LD;
    end
`endif

    // Entering FG services the request, and that clear beats a same-cycle press.
    ped_nxt = ped_pending | ped_req;
    if (state_nxt == FG && state != FG) ped_nxt = 1'b0;
`ifdef TLC_FLASH_MODE_EN
    if (state == FLASH) ped_nxt = ped_pending;
`endif

    hwy_nxt  = 2'b10;
    fwy_nxt  = 2'b10;
    walk_nxt = 1'b0;
    case (state_nxt)
      HG: hwy_nxt = 2'b00;
      HY: hwy_nxt = 2'b01;
      FG: begin
        fwy_nxt  = 2'b00;
        walk_nxt = 1'b1;
      end
      FY: fwy_nxt = 2'b01;
`ifdef TLC_FLASH_MODE_EN
      FLASH: begin
        hwy_nxt = blink_nxt ? 2'b11 : 2'b01;
        fwy_nxt = blink_nxt ? 2'b11 : 2'b01;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HG;
      timer       <= HG_LD;
      ped_pending <= 1'b0;
      hwy         <= 2'b00;
      fwy         <= 2'b10;
      walk        <= 1'b0;
`ifdef TLC_FLASH_MODE_EN
      blink       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      ped_pending <= ped_nxt;
      hwy         <= hwy_nxt;
      fwy         <= fwy_nxt;
      walk        <= walk_nxt;
`ifdef TLC_FLASH_MODE_EN
      blink       <= blink_nxt;
`endif
    end
  end

  assign phase = state;

endmodule
